// File: rtl/frame_pack_pkg.sv
// Shared constants, types and the beat-placement helper for the transmit-side frame packer.
// The packed layout is bit-exact with what the decoder's frame slicer consumes.
package frame_pack_pkg;

    localparam int FRAME_W          = 384;
    localparam int SLICED_INPUT_NUM = 6;
    localparam int BEATS_RATE2      = FRAME_W / 4;
    localparam int BEATS_RATE3      = FRAME_W / 6;
    localparam int FILL_W           = 9;

    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;

    localparam logic [FILL_W-1:0] WP_TOP = FILL_W'(FRAME_W - 1);

    typedef enum logic {
        ST_FILL      = 1'b0,
        ST_FULL_WAIT = 1'b1
    } asm_state_e;

    // Returns a frame-wide word holding one beat's bits at frame[wp] downward, zero elsewhere.
    function automatic logic [FRAME_W-1:0] place_beat(
        input logic                        rate,
        input logic [SLICED_INPUT_NUM-1:0] sym,
        input logic [FILL_W-1:0]           wp
    );
        logic [FRAME_W-1:0] top;
        top = '0;
        if (rate == CODE_RATE_2) begin
            top[FRAME_W-1 -: 4] = {sym[0], sym[1], sym[3], sym[4]};
        end else begin
            top[FRAME_W-1 -: 6] = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
        end
        return top >> (WP_TOP - wp);
    endfunction

endpackage

// File: rtl/frame_out_reg.sv
// Output holding register: carries frame, last flag and fill count under a valid/ready handshake.
// A transfer happens on any edge where o_valid && i_ready; o_can_load says a new frame may be written.
module frame_out_reg
    import frame_pack_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [FRAME_W-1:0] i_frame,
    input  logic               i_last,
    input  logic [FILL_W-1:0]  i_fill,
    input  logic               i_ready,
    output logic               o_can_load,
    output logic               o_valid,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_last,
    output logic [FILL_W-1:0]  o_fill
);

    logic               valid_q, valid_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               last_q, last_d;
    logic [FILL_W-1:0]  fill_q, fill_d;

    assign o_can_load = !valid_q || i_ready;

    always_comb begin
        valid_d = valid_q;
        frame_d = frame_q;
        last_d  = last_q;
        fill_d  = fill_q;
        if (i_load) begin
            valid_d = 1'b1;
            frame_d = i_frame;
            last_d  = i_last;
            fill_d  = i_fill;
        end else if (valid_q && i_ready) begin
            // Consumed with nothing to refill: metadata clears with valid.
            valid_d = 1'b0;
            last_d  = 1'b0;
            fill_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            frame_q <= '0;
            last_q  <= 1'b0;
            fill_q  <= '0;
        end else begin
            valid_q <= valid_d;
            frame_q <= frame_d;
            last_q  <= last_d;
            fill_q  <= fill_d;
        end
    end

    assign o_valid = valid_q;
    assign o_frame = frame_q;
    assign o_last  = last_q;
    assign o_fill  = fill_q;

endmodule

// File: rtl/frame_pack.sv
// Packs two encoded symbols per beat MSB-first into 384-bit frames, double-buffered against the output register.
// Handshake: a beat moves when i_valid && o_ready; a frame moves when o_frame_valid && i_frame_ready.
module frame_pack
    import frame_pack_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_code_rate,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [SLICED_INPUT_NUM-1:0] i_sym,
    input  logic                        i_last,
    output logic [FRAME_W-1:0]          o_frame,
    output logic                        o_frame_valid,
    input  logic                        i_frame_ready,
    output logic                        o_frame_last,
    output logic [FILL_W-1:0]           o_fill,
    output asm_state_e                  o_dbg_state
);

    asm_state_e         state_q, state_d;
    logic [FRAME_W-1:0] asm_q, asm_d;
    logic [FILL_W-1:0]  wp_q, wp_d;
    logic               rate_q, rate_d;
    logic               hold_last_q, hold_last_d;
    logic [FILL_W-1:0]  hold_fill_q, hold_fill_d;

    logic               rate_eff;
    logic [FILL_W-1:0]  step;
    logic [FRAME_W-1:0] merged;
    logic [FILL_W-1:0]  fill_new;
    logic               closes;
    logic               out_load;
    logic               out_can_load;
    logic [FRAME_W-1:0] out_frame;
    logic               out_last;
    logic [FILL_W-1:0]  out_fill;

    // o_ready is a pure decode of the registered state, never of i_frame_ready.
    assign o_ready     = (state_q == ST_FILL);
    assign o_dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        wp_d        = wp_q;
        rate_d      = rate_q;
        hold_last_d = hold_last_q;
        hold_fill_d = hold_fill_q;
        out_load    = 1'b0;
        out_frame   = asm_q;
        out_last    = hold_last_q;
        out_fill    = hold_fill_q;

        // The code rate is only honoured on the first beat of a frame.
        rate_eff = (wp_q == WP_TOP) ? i_code_rate : rate_q;
        step     = (rate_eff == CODE_RATE_2) ? FILL_W'(4) : FILL_W'(6);
        merged   = asm_q | place_beat(rate_eff, i_sym, wp_q);
        fill_new = (WP_TOP - wp_q) + step;
        closes   = (wp_q == step - FILL_W'(1)) || i_last;

        case (state_q)
            ST_FILL: begin
                if (i_valid) begin
                    rate_d = rate_eff;
                    if (closes && out_can_load) begin
                        out_load  = 1'b1;
                        out_frame = merged;
                        out_last  = i_last;
                        out_fill  = fill_new;
                        asm_d     = '0;
                        wp_d      = WP_TOP;
                    end else if (closes) begin
                        asm_d       = merged;
                        hold_last_d = i_last;
                        hold_fill_d = fill_new;
                        state_d     = ST_FULL_WAIT;
                    end else begin
                        asm_d = merged;
                        wp_d  = wp_q - step;
                    end
                end
            end
            ST_FULL_WAIT: begin
                if (out_can_load) begin
                    out_load = 1'b1;
                    asm_d    = '0;
                    wp_d     = WP_TOP;
                    state_d  = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            asm_q       <= '0;
            wp_q        <= WP_TOP;
            rate_q      <= CODE_RATE_2;
            hold_last_q <= 1'b0;
            hold_fill_q <= '0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            wp_q        <= wp_d;
            rate_q      <= rate_d;
            hold_last_q <= hold_last_d;
            hold_fill_q <= hold_fill_d;
        end
    end

    frame_out_reg u_out (
        .clk        (clk),
        .rst        (rst),
        .i_load     (out_load),
        .i_frame    (out_frame),
        .i_last     (out_last),
        .i_fill     (out_fill),
        .i_ready    (i_frame_ready),
        .o_can_load (out_can_load),
        .o_valid    (o_frame_valid),
        .o_frame    (o_frame),
        .o_last     (o_frame_last),
        .o_fill     (o_fill)
    );

endmodule

// File: tb/tb_frame_pack.sv
// Self-checking bench for frame_pack: a bit-list reference model builds expected frames from the symbol stream.
module tb_frame_pack;
    import frame_pack_pkg::*;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_code_rate = CODE_RATE_2;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic [5:0]         i_sym = '0;
    logic               i_last = 1'b0;
    logic [FRAME_W-1:0] o_frame;
    logic               o_frame_valid;
    logic               i_frame_ready;
    logic               o_frame_last;
    logic [FILL_W-1:0]  o_fill;
    asm_state_e         o_dbg_state;

    logic rdy_fixed = 1'b1;
    logic rdy_rand  = 1'b1;
    logic rand_rdy_en = 1'b0;
    assign i_frame_ready = rand_rdy_en ? rdy_rand : rdy_fixed;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rdy_rand = 1'($urandom_range(0, 1));
    end

    frame_pack dut (
        .clk           (clk),
        .rst           (rst),
        .i_code_rate   (i_code_rate),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_sym         (i_sym),
        .i_last        (i_last),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready),
        .o_frame_last  (o_frame_last),
        .o_fill        (o_fill),
        .o_dbg_state   (o_dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic               mdl_bits[$];
    logic               mdl_rate;
    logic [FRAME_W-1:0] exp_q[$];
    logic               exp_last_q[$];
    int                 exp_fill_q[$];

    task automatic model_beat(input logic rate, input logic [5:0] sym, input logic last);
        logic [FRAME_W-1:0] f;
        if (mdl_bits.size() == 0) mdl_rate = rate;
        if (mdl_rate == CODE_RATE_2) begin
            mdl_bits.push_back(sym[0]); mdl_bits.push_back(sym[1]);
            mdl_bits.push_back(sym[3]); mdl_bits.push_back(sym[4]);
        end else begin
            for (int b = 0; b < 6; b++) mdl_bits.push_back(sym[b]);
        end
        if (mdl_bits.size() >= FRAME_W || last) begin
            f = '0;
            for (int i = 0; i < mdl_bits.size(); i++) f[FRAME_W-1-i] = mdl_bits[i];
            exp_q.push_back(f);
            exp_last_q.push_back(last);
            exp_fill_q.push_back(mdl_bits.size());
            mdl_bits.delete();
        end
    endtask

    // ---------------- scoreboard capture ----------------
    logic [FRAME_W-1:0] got_q[$];
    logic               got_last_q[$];
    int                 got_fill_q[$];

    always @(negedge clk) begin
        if (!rst && o_frame_valid && i_frame_ready) begin
            got_q.push_back(o_frame);
            got_last_q.push_back(o_frame_last);
            got_fill_q.push_back(int'(o_fill));
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_beat(input logic rate, input logic [5:0] sym, input logic last);
        logic done;
        done = 1'b0;
        i_valid = 1'b1; i_code_rate = rate; i_sym = sym; i_last = last;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (o_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_last = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL beat_accept: o_ready stayed %0b, required 1 within 2000 cycles", o_ready);
        end
    endtask

    task automatic send(input logic rate, input logic [5:0] sym, input logic last);
        model_beat(rate, sym, last);
        drive_beat(rate, sym, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (got_q.size() >= exp_q.size() && !o_frame_valid) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        mdl_bits.delete(); exp_q.delete(); exp_last_q.delete(); exp_fill_q.delete();
        got_q.delete(); got_last_q.delete(); got_fill_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        total++;
        if (o_frame_valid !== 1'b0 || o_ready !== 1'b1 || o_fill !== '0 ||
            o_frame_last !== 1'b0 || o_frame !== '0) begin
            bad++;
            $display("FAIL reset: valid=%0b ready=%0b fill=%0d last=%0b frame_nz=%0b, required 0/1/0/0/0",
                     o_frame_valid, o_ready, o_fill, o_frame_last, |o_frame);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_rate2_ones();
        rdy_fixed = 1'b1;
        for (int k = 0; k < BEATS_RATE2; k++) begin
            send(CODE_RATE_2, 6'b011_011, 1'b0);
            if (k == BEATS_RATE2 - 2) begin
                total++;
                if (o_frame_valid !== 1'b0) begin
                    bad++; $display("FAIL r2_early_valid: got %0b required 0", o_frame_valid);
                end
            end
        end
        total++;
        if (o_frame_valid !== 1'b1 || o_frame !== {FRAME_W{1'b1}} || o_fill !== 9'd384 ||
            o_frame_last !== 1'b0) begin
            bad++;
            $display("FAIL r2_ones: valid=%0b fill=%0d last=%0b frame=%h, required 1/384/0/all ones",
                     o_frame_valid, o_fill, o_frame_last, o_frame);
        end
        wait_drain();
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            total++;
            if (got_q[0] !== exp_q[0] || got_last_q[0] !== exp_last_q[0] || got_fill_q[0] != exp_fill_q[0]) begin
                bad++;
                $display("FAIL r2_frame: got fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                         got_fill_q[0], got_last_q[0], got_q[0], exp_fill_q[0], exp_last_q[0], exp_q[0]);
            end
            void'(got_q.pop_front()); void'(got_last_q.pop_front()); void'(got_fill_q.pop_front());
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front()); void'(exp_fill_q.pop_front());
        end
        total++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            bad++; $display("FAIL r2_count: got %0d extra frames, required 0 (%0d missing)", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_rate3_inc();
        logic [FRAME_W-1:0] f;
        for (int k = 0; k < BEATS_RATE3; k++) send(CODE_RATE_3, 6'(k), 1'b0);
        f = o_frame;
        total++;
        if (f[383:378] !== 6'b000000 || f[5:0] !== 6'b111111 || o_fill !== 9'd384 || o_frame_last !== 1'b0) begin
            bad++;
            $display("FAIL r3_inc: top=%b bot=%b fill=%0d last=%0b, required 000000/111111/384/0",
                     f[383:378], f[5:0], o_fill, o_frame_last);
        end
        wait_drain();
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            total++;
            if (got_q[0] !== exp_q[0] || got_last_q[0] !== exp_last_q[0] || got_fill_q[0] != exp_fill_q[0]) begin
                bad++;
                $display("FAIL r3_frame: got fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                         got_fill_q[0], got_last_q[0], got_q[0], exp_fill_q[0], exp_last_q[0], exp_q[0]);
            end
            void'(got_q.pop_front()); void'(got_last_q.pop_front()); void'(got_fill_q.pop_front());
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front()); void'(exp_fill_q.pop_front());
        end
    endtask

    task automatic test_partial();
        logic [FRAME_W-1:0] f;
        logic [FRAME_W-1:0] ef;
        for (int k = 0; k < 10; k++) send(CODE_RATE_2, 6'($urandom_range(0, 63)), k == 9);
        f  = o_frame;
        ef = exp_q[0];
        total++;
        if (o_frame_last !== 1'b1 || o_fill !== 9'd40 || f[343:0] !== '0 || f !== ef) begin
            bad++;
            $display("FAIL partial: last=%0b fill=%0d frame=%h, required 1/40/%h", o_frame_last, o_fill, f, ef);
        end
        wait_drain();
        total++;
        if (got_q.size() != 1 || got_last_q[0] !== 1'b1 || got_fill_q[0] != 40) begin
            bad++; $display("FAIL partial_sb: got %0d frames, required 1 with last=1 fill=40", got_q.size());
        end
        clear_model();
    endtask

    task automatic test_backpressure();
        logic [FRAME_W-1:0] f1;
        logic [FRAME_W-1:0] f2;
        rdy_fixed = 1'b0;
        for (int k = 0; k < 2 * BEATS_RATE3; k++) send(CODE_RATE_3, 6'($urandom_range(0, 63)), 1'b0);
        f1 = exp_q[0];
        f2 = exp_q[1];
        total++;
        if (o_ready !== 1'b0 || o_frame_valid !== 1'b1 || o_frame !== f1) begin
            bad++;
            $display("FAIL bp_hold: ready=%0b valid=%0b frame=%h, required 0/1/%h", o_ready, o_frame_valid, o_frame, f1);
        end
        idle(5);
        total++;
        if (o_ready !== 1'b0 || o_frame !== f1 || o_fill !== 9'd384) begin
            bad++;
            $display("FAIL bp_stable: ready=%0b fill=%0d frame=%h, required 0/384/%h", o_ready, o_fill, o_frame, f1);
        end
        rdy_fixed = 1'b1;
        idle(1);
        total++;
        if (o_ready !== 1'b1 || o_frame_valid !== 1'b1 || o_frame !== f2) begin
            bad++;
            $display("FAIL bp_release: ready=%0b valid=%0b frame=%h, required 1/1/%h", o_ready, o_frame_valid, o_frame, f2);
        end
        wait_drain();
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            total++;
            if (got_q[0] !== exp_q[0] || got_last_q[0] !== exp_last_q[0] || got_fill_q[0] != exp_fill_q[0]) begin
                bad++;
                $display("FAIL bp_frame: got fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                         got_fill_q[0], got_last_q[0], got_q[0], exp_fill_q[0], exp_last_q[0], exp_q[0]);
            end
            void'(got_q.pop_front()); void'(got_last_q.pop_front()); void'(got_fill_q.pop_front());
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front()); void'(exp_fill_q.pop_front());
        end
    endtask

    task automatic test_rate_change();
        logic [5:0]         s2;
        logic [FRAME_W-1:0] f;
        s2 = 6'($urandom_range(0, 63));
        send(CODE_RATE_2, 6'($urandom_range(0, 63)), 1'b0);
        send(CODE_RATE_3, s2, 1'b0);
        for (int k = 2; k < BEATS_RATE2; k++) send(CODE_RATE_3, 6'($urandom_range(0, 63)), 1'b0);
        f = o_frame;
        total++;
        if (o_frame_valid !== 1'b1 || o_fill !== 9'd384 || f[379:376] !== {s2[0], s2[1], s2[3], s2[4]}) begin
            bad++;
            $display("FAIL rate_latch: valid=%0b fill=%0d beat2=%b, required 1/384/%b",
                     o_frame_valid, o_fill, f[379:376], {s2[0], s2[1], s2[3], s2[4]});
        end
        for (int k = 0; k < BEATS_RATE3; k++) send(CODE_RATE_3, 6'($urandom_range(0, 63)), 1'b0);
        wait_drain();
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            total++;
            if (got_q[0] !== exp_q[0] || got_last_q[0] !== exp_last_q[0] || got_fill_q[0] != exp_fill_q[0]) begin
                bad++;
                $display("FAIL rc_frame: got fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                         got_fill_q[0], got_last_q[0], got_q[0], exp_fill_q[0], exp_last_q[0], exp_q[0]);
            end
            void'(got_q.pop_front()); void'(got_last_q.pop_front()); void'(got_fill_q.pop_front());
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front()); void'(exp_fill_q.pop_front());
        end
        total++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            bad++; $display("FAIL rc_count: got %0d extra frames, required 0 (%0d missing)", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        rdy_fixed = 1'b0;
        for (int k = 0; k < BEATS_RATE2; k++) send(CODE_RATE_2, 6'($urandom_range(0, 63)), 1'b0);
        for (int k = 0; k < 29; k++) send(CODE_RATE_2, 6'($urandom_range(0, 63)), 1'b0);
        rst = 1'b1; i_valid = 1'b1; i_sym = 6'h3f;
        idle(1);
        rst = 1'b0; i_valid = 1'b0;
        clear_model();
        total++;
        if (o_frame_valid !== 1'b0 || o_frame !== '0 || o_fill !== '0 || o_frame_last !== 1'b0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: valid=%0b fill=%0d last=%0b ready=%0b frame_nz=%0b, required 0/0/0/1/0",
                     o_frame_valid, o_fill, o_frame_last, o_ready, |o_frame);
        end
        rdy_fixed = 1'b1;
        for (int k = 0; k < BEATS_RATE3; k++) send(CODE_RATE_3, 6'($urandom_range(0, 63)), 1'b0);
        wait_drain();
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0] || got_fill_q[0] != 384) begin
            bad++;
            $display("FAIL reset_next: got %0d frames, required 1 matching model (%0d expected)", got_q.size(), exp_q.size());
        end
        clear_model();
    endtask

    task automatic test_random();
        rand_rdy_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy_en = 1'b0;
        rdy_fixed   = 1'b1;
        send(CODE_RATE_3, 6'($urandom_range(0, 63)), 1'b1);
        wait_drain();
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            total++;
            if (got_q[0] !== exp_q[0] || got_last_q[0] !== exp_last_q[0] || got_fill_q[0] != exp_fill_q[0]) begin
                bad++;
                $display("FAIL rand_frame: got fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                         got_fill_q[0], got_last_q[0], got_q[0], exp_fill_q[0], exp_last_q[0], exp_q[0]);
            end
            void'(got_q.pop_front()); void'(got_last_q.pop_front()); void'(got_fill_q.pop_front());
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front()); void'(exp_fill_q.pop_front());
        end
        total++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            bad++; $display("FAIL rand_count: got %0d extra frames, required 0 (%0d missing)", got_q.size(), exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_rate2_ones();
        test_rate3_inc();
        test_partial();
        test_backpressure();
        test_rate_change();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_pack.md
Name: frame_pack

Overview:
- Transmit-side counterpart of the decoder's frame slicer.
- Accepts two encoded symbols per beat from the convolutional encoder (rate 1/2: 2 bits each; rate 1/3: 3 bits each) and packs them MSB-first into a 384-bit frame.
- The resulting frame is bit-exact with what the slicer consumes.
- Double-buffered: one frame assembles while the previous frame waits for DMA/PS handoff.

Parameters:
- FRAME_W, 384, frame width in bits; must be divisible by 4 and 6.
- SYM_NUM, `SLICED_INPUT_NUM (6), symbol-bus width: two symbols of up to 3 bits each.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- i_code_rate  in  1  `CODE_RATE_2 or `CODE_RATE_3; sampled only on the first beat of a frame
- i_valid  in  1  symbol beat valid
- o_ready  out  1  packer can accept a beat
- i_sym  in  SYM_NUM  [2:0]=symbol0, [5:3]=symbol1; bits [2] and [5] ignored at rate 1/2
- i_last  in  1  qualifies the final beat of the stream
- o_frame  out  FRAME_W  packed frame
- o_frame_valid  out  1  o_frame holds a complete frame
- i_frame_ready  in  1  downstream accepts o_frame
- o_frame_last  out  1  frame holds the end of the stream (possibly partial)
- o_fill  out  9  count of valid bits in o_frame (1..384)

Behaviour:
- Reset (sync, active-high, overrides all inputs):
  - o_frame=0, o_frame_valid=0, o_frame_last=0, o_fill=0, o_ready=1.
  - Assembly register cleared, write pointer wp=FRAME_W-1, rate latch = `CODE_RATE_2.
  - Reset mid-frame discards all partial data.
- Beat accept = i_valid && o_ready.
- First beat of a frame (wp==FRAME_W-1) latches i_code_rate. Later beats ignore i_code_rate.
- Rate 1/2 placement per beat:
  - frame[wp]=i_sym[0], [wp-1]=i_sym[1], [wp-2]=i_sym[3], [wp-3]=i_sym[4]
  - wp -= 4
  - 96 beats per frame
- Rate 1/3 placement per beat:
  - frame[wp..wp-5] = i_sym[0], i_sym[1], i_sym[2], i_sym[3], i_sym[4], i_sym[5]
  - wp -= 6
  - 64 beats per frame
- The frame closes on an accepted beat that fills bit 0, or on an accepted beat with i_last=1.
  - Unwritten bits are zero.
  - Fill = FRAME_W-1-wp_after+1.
  - Partial close sets the last flag. A full frame closed by an i_last beat also sets it.
- Output handoff:
  - A closed frame moves to the output register on the next edge if the output register is empty or is being consumed that cycle (o_frame_valid && i_frame_ready).
  - Latency: closing beat accepted at edge N gives o_frame_valid=1 from N+1.
  - The assembly register then resets (wp=FRAME_W-1), so the next beat can be accepted at N+1. Back-to-back frames run without bubbles while downstream keeps up.
- Hold state: when a closed frame cannot move (output valid and not consumed):
  - Assembly holds it and o_ready=0.
  - Transfer occurs on the edge where i_frame_ready=1, and o_ready returns to 1 the following cycle.
- Output register:
  - o_frame, o_frame_last and o_fill stay stable while o_frame_valid=1 and i_frame_ready=0.
  - Consumption without refill clears o_frame_valid, o_frame_last and o_fill next edge.
- i_last with no prior beat is not possible: i_last is only qualified with i_valid. i_valid=0 leaves all state unchanged.
- o_ready is a registered function of the assembly-full flag. It does not combinationally depend on i_frame_ready.
- State machine for the assembly side:
  - FILL -> FULL_WAIT on close when transfer is blocked.
  - FULL_WAIT -> FILL on transfer.
  - FILL -> FILL on close with transfer.

Decomposition:
- Add to param_def.sv:
  - FRAME_W=384
  - beats-per-frame constants (96, 64)
  - fill-counter width 9
- Reuse the existing `CODE_RATE_2, `CODE_RATE_3 and `SLICED_INPUT_NUM.
- One sub-module: frame_out_reg. It is the output holding register with valid/ready and carries frame, last and fill.

Test Plan:
- Rate 1/2, 96 beats of i_sym=6'b011_011, i_frame_ready=1 -> one frame with all bits 1, o_fill=384, o_frame_last=0, o_frame_valid one cycle after beat 96. Feeding the frame into the slicer reproduces the input symbols.
- Rate 1/3, 64 beats with incrementing i_sym (beat k = k[5:0]) -> frame[383:378]=bits of beat0 in i_sym[0..5] order, frame[5:0]=beat63 likewise, o_fill=384.
- Rate 1/2, 10 beats, i_last on beat 10 -> o_frame_last=1, o_fill=40, frame[343:0]=0.
- Backpressure: i_frame_ready=0, stream 2 full rate-1/3 frames -> o_ready drops after beat 128 closes frame 2. Frame 1 stays stable. Raising i_frame_ready moves frame 2 out next edge, then o_ready=1.
- Rate change mid-frame: rate 1/2 on beat 1, rate 1/3 on beat 2 -> beat 2 is still packed at 4 bits. The next frame latches rate 1/3.
- Reset asserted at beat 30 with o_frame_valid=1 -> next cycle all outputs zero, o_ready=1. The following frame starts at bit 383.
